read2control: RTL

// Read-side counterpart of the buffer write controller. After a one-cycle config pulse it fetches packed
// 32-bit words (4 x int8) from the X_MAC*X_MESH buffer RAMs and unpacks them into a valid/ready byte stream.

---
 rtl/read2control_pkg.sv | 23 ++
 rtl/read2control_byte_unpack.sv | 38 +++
 rtl/read2control.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/read2control_pkg.sv
// Shared state encoding, byte geometry and column selection for the read2control slice.
package read2control_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_CAPTURE,
      ST_DRAIN
   } state_e;

   // Column j is read when it is the first column, or its wrap-around neighbour in wide mode.
   function automatic logic col_sel(input logic [1:0] valid_mac, input logic wide,
                                    input logic [1:0] j);
      logic [1:0] nb;
      nb = valid_mac + 2'd1;
      return (j == valid_mac) || (wide && (j == nb));
   endfunction

endpackage

// File: rtl/read2control_byte_unpack.sv
// Per-row lane mapping from the captured word pair to narrow and wide beat lanes.
// Optional build macro: READ2CONTROL_ZERO_PAD_EN zeroes unused and unselected lanes.
module read2control_byte_unpack
   import read2control_pkg::*;
(
   input  logic [31:0] word0,
   input  logic [31:0] word1,
   input  logic [1:0]  beat,
   input  logic        wide,
   input  logic        odd_tail,
   output logic [7:0]  out_1,
   output logic [31:0] out_4
);

   logic [15:0] half0;
   logic [15:0] half1;

   always_comb begin
      out_1 = word0[beat*BYTE_W +: BYTE_W];
      half0 = word0[beat[0]*16 +: 16];
      half1 = word1[beat[0]*16 +: 16];
`ifdef READ2CONTROL_ZERO_PAD_EN
      if (!wide) begin
         half1 = '0;
      end else if (odd_tail) begin
         half0[15:8] = '0;
         half1[15:8] = '0;
      end
`endif
      out_4 = {half1, half0};
   end

`ifndef READ2CONTROL_ZERO_PAD_EN
   logic unused_pad;
   assign unused_pad = wide ^ odd_tail;
`endif

endmodule

// File: rtl/read2control.sv
// Buffer read controller: fetches packed int8 words per mesh row and streams them as beats.
// Optional build macro: READ2CONTROL_ZERO_PAD_EN (lane padding in read2control_byte_unpack).
module read2control
   import read2control_pkg::*;
#(
   parameter int unsigned X_MAC        = 4,
   parameter int unsigned X_MESH       = 16,
   parameter int unsigned ADDR_LEN     = 13,
   parameter int unsigned DATA_LEN     = 32,
   parameter int unsigned MAX_LINE_LEN = 10,
   parameter int unsigned RAM_LATENCY  = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                conf_input,
   input  logic [ADDR_LEN*X_MAC-1:0]           st_addr,
   input  logic [MAX_LINE_LEN-1:0]             linelen,
   input  logic [1:0]                          valid_mac,
   input  logic                                wide,
   output logic [X_MAC*X_MESH*ADDR_LEN-1:0]    addrb,
   output logic [X_MAC*X_MESH-1:0]             enb,
   input  logic [X_MAC*X_MESH*DATA_LEN-1:0]    doutb,
   output logic [8*X_MESH-1:0]                 out_data_1,
   output logic [32*X_MESH-1:0]                out_data_4,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                req,
   output logic                                idle
);

   localparam int unsigned BUFFER_NUM = X_MAC * X_MESH;

   state_e                     state_q;
   logic [ADDR_LEN*X_MAC-1:0]  st_addr_q;
   logic [MAX_LINE_LEN-1:0]    left_q;
   logic [1:0]                 vmac_q;
   logic                       wide_q;
   logic [ADDR_LEN-1:0]        wcnt_q;
   logic [1:0]                 beat_q;
   logic [7:0]                 wait_q;
   logic                       req_q;
   logic                       valid_q;
   logic [BUFFER_NUM-1:0]      enb_q;
   logic [X_MESH*DATA_LEN-1:0] word0_q;
   logic [X_MESH*DATA_LEN-1:0] word1_q;

   logic [X_MAC-1:0]           conf_mask;
   logic [X_MAC-1:0]           cur_mask;
   logic [X_MESH*DATA_LEN-1:0] cap0;
   logic [X_MESH*DATA_LEN-1:0] cap1;
   logic [1:0]                 nb;
   logic [MAX_LINE_LEN-1:0]    left_nx;
   logic                       word_end;
   logic                       odd_tail;

   always_comb begin
      conf_mask = '0;
      cur_mask  = '0;
      for (int j = 0; j < X_MAC; j++) begin
         conf_mask[j] = col_sel(valid_mac, wide, 2'(j));
         cur_mask[j]  = col_sel(vmac_q, wide_q, 2'(j));
      end
   end

   // Every row of a column shares one address: start address plus words already fetched.
   always_comb begin
      addrb = '0;
      for (int i = 0; i < X_MESH; i++) begin
         for (int j = 0; j < X_MAC; j++) begin
            addrb[(j + i*X_MAC)*ADDR_LEN +: ADDR_LEN] = st_addr_q[j*ADDR_LEN +: ADDR_LEN] + wcnt_q;
         end
      end
   end

   always_comb begin
      nb   = vmac_q + 2'd1;
      cap0 = '0;
      cap1 = '0;
      for (int i = 0; i < X_MESH; i++) begin
         cap0[i*DATA_LEN +: DATA_LEN] = doutb[(int'(vmac_q) + i*X_MAC)*DATA_LEN +: DATA_LEN];
         cap1[i*DATA_LEN +: DATA_LEN] = doutb[(int'(nb) + i*X_MAC)*DATA_LEN +: DATA_LEN];
      end
   end

   always_comb begin
      if (wide_q && (left_q >= MAX_LINE_LEN'(2))) begin
         left_nx = left_q - MAX_LINE_LEN'(2);
      end else begin
         left_nx = left_q - MAX_LINE_LEN'(1);
      end
      word_end = wide_q ? beat_q[0] : (beat_q == 2'(BYTES_PER_WORD - 1));
      odd_tail = wide_q && (left_q == MAX_LINE_LEN'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         st_addr_q <= '0;
         left_q    <= '0;
         vmac_q    <= '0;
         wide_q    <= 1'b0;
         wcnt_q    <= '0;
         beat_q    <= '0;
         wait_q    <= '0;
         req_q     <= 1'b0;
         valid_q   <= 1'b0;
         enb_q     <= '0;
         word0_q   <= '0;
         word1_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // A set req in idle is the one-cycle pulse of a zero-length line.
               if (req_q) begin
                  req_q <= 1'b0;
               end else if (conf_input) begin
                  st_addr_q <= st_addr;
                  left_q    <= linelen;
                  vmac_q    <= valid_mac;
                  wide_q    <= wide;
                  wcnt_q    <= '0;
                  beat_q    <= '0;
                  req_q     <= 1'b1;
                  if (linelen != '0) begin
                     state_q <= ST_FETCH;
                     enb_q   <= {X_MESH{conf_mask}};
                  end
               end
            end
            ST_FETCH: begin
               enb_q   <= '0;
               wcnt_q  <= wcnt_q + ADDR_LEN'(1);
               wait_q  <= '0;
               state_q <= (RAM_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
            end
            ST_WAIT: begin
               if (wait_q == 8'(RAM_LATENCY - 2)) begin
                  state_q <= ST_CAPTURE;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            ST_CAPTURE: begin
               word0_q <= cap0;
               word1_q <= cap1;
               valid_q <= 1'b1;
               state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  left_q <= left_nx;
                  if (left_nx == '0) begin
                     state_q <= ST_IDLE;
                     req_q   <= 1'b0;
                     valid_q <= 1'b0;
                  end else if (word_end) begin
                     state_q <= ST_FETCH;
                     enb_q   <= {X_MESH{cur_mask}};
                     valid_q <= 1'b0;
                     beat_q  <= '0;
                  end else begin
                     beat_q <= beat_q + 2'd1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < X_MESH; i++) begin : g_row
      read2control_byte_unpack u_unpack (
         .word0    (word0_q[i*DATA_LEN +: DATA_LEN]),
         .word1    (word1_q[i*DATA_LEN +: DATA_LEN]),
         .beat     (beat_q),
         .wide     (wide_q),
         .odd_tail (odd_tail),
         .out_1    (out_data_1[i*8 +: 8]),
         .out_4    (out_data_4[i*32 +: 32])
      );
   end

   assign enb       = enb_q;
   assign out_valid = valid_q;
   assign req       = req_q;
   assign idle      = !req_q && (state_q == ST_IDLE);

endmodule
